updown_counter_mod: RTL and testbench

UPDOWN_COUNTER_MOD -- requirements
Module: updown_counter_mod

---
 rtl/updown_counter_mod.sv | 96 +++++++++
 tb/tb_updown_counter_mod.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Modulo-MODULUS up/down counter with parallel load, wrap/saturate ends,
// a range-end pulse, a sticky overflow flag and an out-of-range load pulse.
module updown_counter_mod #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MODULUS  = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             load_err_q, load_err_d;

    logic at_top;
    logic at_bot;
    logic load_in_range;
    logic range_end;

    assign at_top        = (count_q == MAX_VAL);
    assign at_bot        = (count_q == '0);
    assign load_in_range = (32'(load_val) < MODULUS);

    // Terminal count is purely combinational on the current count and inputs
    assign tc        = en && (up ? at_top : at_bot);
    assign range_end = tc && !load;

    // Next-state: load beats counting; range end either wraps or holds
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        ovf_d      = ovf_q;
        load_err_d = 1'b0;

        if (load) begin
            if (load_in_range) begin
                count_d = load_val;
            end else begin
                count_d    = MAX_VAL;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (tc) begin
                if (SATURATE != 0) begin
                    count_d = count_q;
                end else begin
                    count_d = up ? '0 : MAX_VAL;
                end
            end else begin
                count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
            end
        end

        // A range-end event on the same edge overrides a flag clear
        if (range_end) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
        end else if (clr_flag) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Drives four counter configurations from shared inputs and compares each
// against an arithmetic reference model.
module tb_updown_counter_mod;

    localparam int unsigned W  = 3;
    localparam int unsigned ND = 4;

    logic clk = 1'b0;
    logic reset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, clr_flag = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [ND-1:0][W-1:0] cnt_o;
    logic [ND-1:0]        tc_o, wrap_o, ovf_o, lerr_o;

    int mods [ND] = '{8, 5, 8, 2};
    bit sats [ND] = '{1'b0, 1'b0, 1'b1, 1'b0};

    int mc [ND];
    int mw [ND];
    int mo [ND];
    int ml [ND];
    bit tc_exp  [ND];
    logic tc_seen [ND];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(W), .MODULUS(8), .SATURATE(0)) u_m8w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .count(cnt_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]),
        .ovf(ovf_o[0]), .load_err(lerr_o[0]));
    updown_counter_mod #(.WIDTH(W), .MODULUS(5), .SATURATE(0)) u_m5w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .count(cnt_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]),
        .ovf(ovf_o[1]), .load_err(lerr_o[1]));
    updown_counter_mod #(.WIDTH(W), .MODULUS(8), .SATURATE(1)) u_m8s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .count(cnt_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]),
        .ovf(ovf_o[2]), .load_err(lerr_o[2]));
    updown_counter_mod #(.WIDTH(W), .MODULUS(2), .SATURATE(0)) u_m2w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .count(cnt_o[3]), .tc(tc_o[3]), .wrap(wrap_o[3]),
        .ovf(ovf_o[3]), .load_err(lerr_o[3]));

    // Apply inputs, sample tc before the edge, advance model across the edge
    task automatic drive_edge(input bit r, input bit e, input bit u, input bit l,
                              input int lv, input bit c);
        reset = r; en = e; up = u; load = l; load_val = W'(lv); clr_flag = c;
        #1;
        for (int d = 0; d < ND; d++) begin
            tc_seen[d] = tc_o[d];
            tc_exp[d]  = e && (u ? (mc[d] == mods[d] - 1) : (mc[d] == 0));
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            int nxt;
            bit ev;
            ev = 1'b0;
            if (r) begin
                mc[d] = 0; mw[d] = 0; mo[d] = 0; ml[d] = 0;
            end else begin
                if (l) begin
                    ml[d] = (lv >= mods[d]) ? 1 : 0;
                    mc[d] = (lv >= mods[d]) ? mods[d] - 1 : lv;
                    mw[d] = 0;
                end else begin
                    ml[d] = 0;
                    if (e) begin
                        nxt = u ? mc[d] + 1 : mc[d] - 1;
                        ev  = (nxt < 0) || (nxt >= mods[d]);
                        if (ev) nxt = sats[d] ? mc[d] : (nxt + mods[d]) % mods[d];
                        mc[d] = nxt;
                    end
                    mw[d] = ev ? 1 : 0;
                end
                if (ev) mo[d] = 1;
                else if (c) mo[d] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive_edge(1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b1);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d]} !== 6'b000_000) begin
                errors++;
                $display("FAIL reset dut%0d got {cnt,wrap,ovf,lerr}=%b required 000000", d,
                         {cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d]});
            end
        end
    endtask

    task automatic test_count_up();
        int seq [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_edge(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
            checks++;
            if ({cnt_o[0], wrap_o[0], ovf_o[0]} !== {W'(seq[i]), i == 7, i >= 7}) begin
                errors++;
                $display("FAIL count_up step%0d got {cnt,wrap,ovf}=%b required %b", i,
                         {cnt_o[0], wrap_o[0], ovf_o[0]}, {W'(seq[i]), i == 7, i >= 7});
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d], tc_seen[d]} !==
                    {W'(mc[d]), mw[d] != 0, mo[d] != 0, ml[d] != 0, tc_exp[d]}) begin
                    errors++;
                    $display("FAIL count_up model dut%0d got %b required %b", d,
                             {cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d], tc_seen[d]},
                             {W'(mc[d]), mw[d] != 0, mo[d] != 0, ml[d] != 0, tc_exp[d]});
                end
            end
        end
    endtask

    task automatic test_count_down();
        int seq [6] = '{4, 3, 2, 1, 0, 4};
        drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_edge(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
            checks++;
            // tc was sampled while count was 0 at i==0 and i==5
            if ({cnt_o[1], wrap_o[1], tc_seen[1]} !== {W'(seq[i]), i == 0 || i == 5, i == 0 || i == 5}) begin
                errors++;
                $display("FAIL count_down step%0d got {cnt,wrap,tc}=%b required %b", i,
                         {cnt_o[1], wrap_o[1], tc_seen[1]}, {W'(seq[i]), i == 0 || i == 5, i == 0 || i == 5});
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d], tc_seen[d]} !==
                    {W'(mc[d]), mw[d] != 0, mo[d] != 0, ml[d] != 0, tc_exp[d]}) begin
                    errors++;
                    $display("FAIL count_down model dut%0d got %b required %b", d,
                             {cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d], tc_seen[d]},
                             {W'(mc[d]), mw[d] != 0, mo[d] != 0, ml[d] != 0, tc_exp[d]});
                end
            end
        end
    endtask

    task automatic test_saturate();
        drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_edge(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
            checks++;
            if ({cnt_o[2], wrap_o[2], ovf_o[2]} !== {W'(i >= 6 ? 7 : i + 1), i >= 7, i >= 7}) begin
                errors++;
                $display("FAIL saturate step%0d got {cnt,wrap,ovf}=%b required %b", i,
                         {cnt_o[2], wrap_o[2], ovf_o[2]}, {W'(i >= 6 ? 7 : i + 1), i >= 7, i >= 7});
            end
        end
    endtask

    task automatic test_load();
        drive_edge(1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b0);
        checks++;
        if ({cnt_o[1], lerr_o[1], wrap_o[1]} !== {3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL load_oor got {cnt,lerr,wrap}=%b required 10010", {cnt_o[1], lerr_o[1], wrap_o[1]});
        end
        drive_edge(1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d]} !==
                {W'(mc[d]), mw[d] != 0, mo[d] != 0, ml[d] != 0}) begin
                errors++;
                $display("FAIL load_in dut%0d got %b required %b", d,
                         {cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d]},
                         {W'(mc[d]), mw[d] != 0, mo[d] != 0, ml[d] != 0});
            end
        end
        checks++;
        if ({cnt_o[1], lerr_o[1], wrap_o[1]} !== {3'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_ok got {cnt,lerr,wrap}=%b required 01000", {cnt_o[1], lerr_o[1], wrap_o[1]});
        end
    endtask

    task automatic test_clr_flag();
        drive_edge(1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b0);
        drive_edge(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        drive_edge(1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b0);
        drive_edge(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        checks++;
        if ({cnt_o[0], wrap_o[0], ovf_o[0]} !== {3'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL clr_with_wrap got {cnt,wrap,ovf}=%b required 00011", {cnt_o[0], wrap_o[0], ovf_o[0]});
        end
        drive_edge(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        checks++;
        if ({wrap_o[0], ovf_o[0]} !== 2'b00) begin
            errors++;
            $display("FAIL clr_alone got {wrap,ovf}=%b required 00", {wrap_o[0], ovf_o[0]});
        end
    endtask

    task automatic test_reset_mid();
        drive_edge(1'b0, 1'b0, 1'b0, 1'b1, 5, 1'b0);
        drive_edge(1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        checks++;
        if ({cnt_o[0], wrap_o[0], ovf_o[0], lerr_o[0]} !== 6'b000_000) begin
            errors++;
            $display("FAIL reset_mid got {cnt,wrap,ovf,lerr}=%b required 000000",
                     {cnt_o[0], wrap_o[0], ovf_o[0], lerr_o[0]});
        end
        drive_edge(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (cnt_o[0] !== 3'd1) begin
            errors++;
            $display("FAIL reset_resume got count=%0d required 1", cnt_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // Modulus 2 with direction alternating: every edge is a range end
        for (int i = 0; i < 6; i++) begin
            drive_edge(1'b0, 1'b1, (i % 2) == 1, 1'b0, 0, 1'b0);
            checks++;
            if ({cnt_o[3], wrap_o[3], ovf_o[3]} !== {W'((i + 1) % 2), 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL back_to_back step%0d got {cnt,wrap,ovf}=%b required %b", i,
                         {cnt_o[3], wrap_o[3], ovf_o[3]}, {W'((i + 1) % 2), 1'b1, 1'b1});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_edge($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                       int'($urandom_range(0, 7)), $urandom_range(0, 5) == 0);
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d], tc_seen[d]} !==
                    {W'(mc[d]), mw[d] != 0, mo[d] != 0, ml[d] != 0, tc_exp[d]}) begin
                    errors++;
                    $display("FAIL random cyc%0d dut%0d got %b required %b", i, d,
                             {cnt_o[d], wrap_o[d], ovf_o[d], lerr_o[d], tc_seen[d]},
                             {W'(mc[d]), mw[d] != 0, mo[d] != 0, ml[d] != 0, tc_exp[d]});
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            mc[d] = 0; mw[d] = 0; mo[d] = 0; ml[d] = 0;
        end
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load();
        test_clr_flag();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
